// File: rtl/gsm_pkg.sv
// Shared constants and state encoding for the GSM SMS frame sender.
package gsm_pkg;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int FRAME_BYTES = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; a byte offered during the last stop cycle follows with no gap.
module uart_tx_byte
    import gsm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    state_t        st;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;
    logic          tick;

    assign tick  = (cnt == LAST);
    assign ready = (st == IDLE) || (st == STOP && tick);

    always_comb begin
        tx = 1'b1;
        unique case (st)
            START:   tx = 1'b0;
            DATA:    tx = sh[0];
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st      <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (valid) begin
                        sh  <= data;
                        cnt <= '0;
                        st  <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        st      <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt <= '0;
                        sh  <= {1'b0, sh[7:1]};
                        if (bit_idx == 3'd7) st <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt <= '0;
                        if (valid) begin
                            sh <= data;
                            st <= START;
                        end else begin
                            st <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gsm_sms_sender.sv
// Builds the 7-byte SMS frame (header, snapshot, XOR checksum) and
// queues at most one extra request while a frame is on the wire.
module gsm_sms_sender
    import gsm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        send_gsm,
    input  logic [1:0]  alert_level,
    input  logic [15:0] energy_units,
    input  logic [15:0] bill_amount,
    output logic        uart_tx,
    output logic        busy,
    output logic        sms_done,
    output logic        req_dropped
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES);

    state_t      state;
    logic        send_q;
    logic        pending;
    logic        req;
    logic        launch;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  idx;
    logic [1:0]  alert_s;
    logic [15:0] energy_s;
    logic [15:0] bill_s;
    logic [7:0]  csum;
    logic [7:0]  tx_data;

    assign req  = send_gsm & ~send_q;
    assign csum = HDR ^ {6'b0, alert_s} ^ energy_s[15:8] ^ energy_s[7:0]
                ^ bill_s[15:8] ^ bill_s[7:0];

    // The header is constant, so byte 0 can go out on the request edge itself.
    always_comb begin
        tx_data = HDR;
        unique case (idx)
            3'd1:    tx_data = {6'b0, alert_s};
            3'd2:    tx_data = energy_s[15:8];
            3'd3:    tx_data = energy_s[7:0];
            3'd4:    tx_data = bill_s[15:8];
            3'd5:    tx_data = bill_s[7:0];
            3'd6:    tx_data = csum;
            default: tx_data = HDR;
        endcase
    end

    always_comb begin
        launch = 1'b0;
        unique case (state)
            IDLE:    launch = req;
            DONE:    launch = pending | req;
            default: launch = 1'b0;
        endcase
    end

    assign tx_valid    = launch | (state == START && idx != LAST_IDX);
    assign busy        = (state == START) | (state == DONE && pending);
    assign sms_done    = (state == DONE);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .reset_n(reset_n),
        .data   (tx_data),
        .valid  (tx_valid),
        .ready  (tx_ready),
        .tx     (uart_tx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            send_q      <= 1'b0;
            pending     <= 1'b0;
            idx         <= '0;
            alert_s     <= '0;
            energy_s    <= '0;
            bill_s      <= '0;
            req_dropped <= 1'b0;
        end else begin
            send_q      <= send_gsm;
            req_dropped <= 1'b0;
            if (launch) begin
                alert_s  <= alert_level;
                energy_s <= energy_units;
                bill_s   <= bill_amount;
                idx      <= 3'd1;
            end
            unique case (state)
                IDLE: begin
                    if (launch) state <= START;
                end
                START: begin
                    if (tx_valid && tx_ready) idx <= idx + 3'd1;
                    if (req && pending) req_dropped <= 1'b1;
                    else if (req) pending <= 1'b1;
                    if (tx_ready && idx == LAST_IDX) begin
                        state <= DONE;
                        idx   <= '0;
                    end
                end
                DONE: begin
                    // A request landing here is queued behind the frame now launching.
                    state   <= launch ? START : IDLE;
                    pending <= pending & req;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
